// File: rtl/display_pkg.sv
// Shared display-path definitions: default game palette and colour expansion.
package display_pkg;

    localparam int unsigned DEFAULT_COLOR_W = 12;

    // Widest colour word the nibble expansion can produce.
    localparam int unsigned COLOR_MAX_W = 96;

    // Standard game colours, 4 bits per channel, R,G,B from MSB.
    localparam logic [11:0] DEFAULT_PAL4 [8] = '{
        12'h444, 12'hccc, 12'h0f0, 12'h0c0,
        12'hff0, 12'hdd0, 12'hf00, 12'hd00
    };

    // Colour for every entry beyond the eight standard ones.
    localparam logic [11:0] OTHER_COLOR4 = 12'h111;

    function automatic logic [11:0] default_color4(input int unsigned idx);
        if (idx < 8) begin
            return DEFAULT_PAL4[idx[2:0]];
        end
        return OTHER_COLOR4;
    endfunction

    // Places each 4-bit channel nibble in the MSBs of its color_w/3-bit
    // channel field, zero-filling the low bits.
    function automatic logic [COLOR_MAX_W-1:0] expand_color(input logic [11:0] c4,
                                                            input int unsigned color_w);
        int unsigned cw;
        logic [COLOR_MAX_W-1:0] r;
        cw = color_w / 3;
        r  = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            r = r | (COLOR_MAX_W'((c4 >> (4 * ch)) & 12'h00f) << (ch * cw + cw - 4));
        end
        return r;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink half-period counter with a phase toggle; held at zero
// while disabled so every enable starts a fresh on-phase.
module blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_phase
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Count 0..BLINK_DIV-1, toggle phase on wrap; clear when reset or disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/palette_lut.sv
// Programmable colour palette: register-file lookup with one-cycle latency,
// per-entry blink attribute, write forwarding and a CPU readback port.
module palette_lut
    import display_pkg::*;
#(
    parameter int unsigned         ID_W        = 4,
    parameter int unsigned         COLOR_W     = DEFAULT_COLOR_W,
    parameter int unsigned         BLINK_DIV   = 25000000,
    parameter logic [COLOR_W-1:0]  BLANK_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [ID_W-1:0]    color_id,
    output logic               out_valid,
    output logic [COLOR_W-1:0] color,
    input  logic               blink_en,
    input  logic               wr_en,
    input  logic [ID_W-1:0]    wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               wr_blink,
    input  logic [ID_W-1:0]    rd_addr,
    output logic [COLOR_W:0]   rd_data
);

    localparam int unsigned DEPTH = 1 << ID_W;

    logic [COLOR_W-1:0] r_pal [DEPTH];
    logic [DEPTH-1:0]   r_blink;
    logic               r_out_valid;
    logic [COLOR_W-1:0] r_color;
    logic [COLOR_W:0]   r_rd_data;

    logic               w_phase;
    logic [COLOR_W-1:0] w_lk_color;
    logic               w_lk_blink;
    logic [COLOR_W-1:0] w_rd_color;
    logic               w_rd_blink;
    logic               w_blank;

    blink_timer #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (blink_en),
        .o_phase(w_phase)
    );

    // Entry lookup for both ports, forwarding a same-cycle write to that index.
    always_comb begin
        w_lk_color = r_pal[color_id];
        w_lk_blink = r_blink[color_id];
        w_rd_color = r_pal[rd_addr];
        w_rd_blink = r_blink[rd_addr];
        if (wr_en && (wr_addr == color_id)) begin
            w_lk_color = wr_data;
            w_lk_blink = wr_blink;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            w_rd_color = wr_data;
            w_rd_blink = wr_blink;
        end
        w_blank = blink_en && w_phase && w_lk_blink;
    end

    // Palette storage: reset to the expanded default palette, CPU writes after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pal[ID_W'(i)] <= COLOR_W'(expand_color(default_color4(i), COLOR_W));
            end
            r_blink <= '0;
        end else if (wr_en) begin
            r_pal[wr_addr]   <= wr_data;
            r_blink[wr_addr] <= wr_blink;
        end
    end

    // Lookup pipeline and readback register; color holds when no request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_color     <= '0;
            r_rd_data   <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_color <= w_blank ? BLANK_COLOR : w_lk_color;
            end
            r_rd_data <= {w_rd_blink, w_rd_color};
        end
    end

    assign out_valid = r_out_valid;
    assign color     = r_color;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: stimulus pushes per-cycle expectations
// from a behavioural model; a negedge monitor pops and compares.
module tb_palette_lut;

    localparam int unsigned DIV = 4;

    typedef struct {
        bit          v;
        logic [11:0] c;
        logic [12:0] rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  color_id;
    logic        out_valid;
    logic [11:0] color;
    logic        blink_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_blink;
    logic [3:0]  rd_addr;
    logic [12:0] rd_data;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    logic [11:0] DEF [16] = '{
        12'h444, 12'hccc, 12'h0f0, 12'h0c0, 12'hff0, 12'hdd0, 12'hf00, 12'hd00,
        12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 12'h111
    };

    logic [11:0] m_pal [16];
    bit          m_blk [16];
    int          m_en_cycles;
    logic [11:0] m_color;

    palette_lut #(
        .ID_W       (4),
        .COLOR_W    (12),
        .BLINK_DIV  (DIV),
        .BLANK_COLOR(12'h000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .color_id (color_id),
        .out_valid(out_valid),
        .color    (color),
        .blink_en (blink_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_blink (wr_blink),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one expectation per clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("color", 32'(color), 32'(e.c));
            chk("rd_data", 32'(rd_data), 32'(e.rd));
        end
    end

    // Model the edge that the current inputs will see, then advance one cycle.
    task automatic step();
        exp_t        e;
        bit          phase;
        logic [11:0] col;
        bit          b;
        logic [11:0] rcol;
        bit          rb;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_pal[i] = DEF[i];
                m_blk[i] = 1'b0;
            end
            m_en_cycles = 0;
            m_color     = 12'h000;
            e.v  = 1'b0;
            e.c  = 12'h000;
            e.rd = 13'h0000;
        end else begin
            // Phase is off for the first DIV enabled cycles, on for the next DIV, etc.
            phase = ((m_en_cycles / DIV) % 2) == 1;
            col  = (wr_en && wr_addr == color_id) ? wr_data  : m_pal[color_id];
            b    = (wr_en && wr_addr == color_id) ? wr_blink : m_blk[color_id];
            rcol = (wr_en && wr_addr == rd_addr)  ? wr_data  : m_pal[rd_addr];
            rb   = (wr_en && wr_addr == rd_addr)  ? wr_blink : m_blk[rd_addr];
            if (in_valid) m_color = (blink_en && phase && b) ? 12'h000 : col;
            e.v  = in_valid;
            e.c  = m_color;
            e.rd = {rb, rcol};
            if (wr_en) begin
                m_pal[wr_addr] = wr_data;
                m_blk[wr_addr] = wr_blink;
            end
            m_en_cycles = blink_en ? m_en_cycles + 1 : 0;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit iv, input logic [3:0] id, input bit be,
                         input bit we, input logic [3:0] wa, input logic [11:0] wd,
                         input bit wb, input logic [3:0] ra);
        rst_n    = r;
        in_valid = iv;
        color_id = id;
        blink_en = be;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        wr_blink = wb;
        rd_addr  = ra;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit be;
        logic [3:0] id;
        logic [3:0] wa;
        int guard;

        // Reset, then sweep default palette.
        drive(0, 0, 4'd0, 0, 0, 4'd0, 12'h000, 0, 4'd0);
        drive(0, 1, 4'd0, 0, 0, 4'd0, 12'h000, 0, 4'd0);
        for (int i = 0; i < 16; i++) drive(1, 1, 4'(i), 0, 0, 4'd0, 12'h000, 0, 4'(i));
        drive(1, 0, 4'd0, 0, 0, 4'd0, 12'h000, 0, 4'd0);

        // Write then read entry 3.
        drive(1, 0, 4'd0, 0, 1, 4'd3, 12'habc, 0, 4'd0);
        drive(1, 1, 4'd3, 0, 0, 4'd0, 12'h000, 0, 4'd3);

        // Collision forwarding on both ports.
        drive(1, 1, 4'd5, 0, 1, 4'd5, 12'h123, 0, 4'd5);
        drive(1, 1, 4'd5, 0, 0, 4'd0, 12'h000, 0, 4'd5);

        // Blink entry 6; id 6 alternates, id 2 is steady.
        drive(1, 0, 4'd0, 0, 1, 4'd6, 12'hf00, 1, 4'd6);
        for (int i = 0; i < 16; i++) drive(1, 1, 4'd6, 1, 0, 4'd0, 12'h000, 0, 4'd6);
        for (int i = 0; i < 8; i++)  drive(1, 1, 4'd2, 1, 0, 4'd0, 12'h000, 0, 4'd2);

        // Reach an off-phase, then drop blink_en; re-enable restarts the on-phase.
        guard = 0;
        while (((m_en_cycles / DIV) % 2) != 1 && guard < 16) begin
            drive(1, 1, 4'd6, 1, 0, 4'd0, 12'h000, 0, 4'd6);
            guard++;
        end
        drive(1, 1, 4'd6, 1, 0, 4'd0, 12'h000, 0, 4'd6);
        drive(1, 1, 4'd6, 0, 0, 4'd0, 12'h000, 0, 4'd6);
        for (int i = 0; i < 10; i++) drive(1, 1, 4'd6, 1, 0, 4'd0, 12'h000, 0, 4'd6);

        // Randomised traffic with occasional resets and collisions.
        be = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) be = ~be;
            id = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? id : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), id, be,
                  ($urandom_range(0, 3) == 0), wa, 12'($urandom), ($urandom_range(0, 1) == 1),
                  4'($urandom_range(0, 15)));
        end

        // Reset mid-operation after custom writes; simultaneous write is lost.
        drive(1, 0, 4'd0, 1, 1, 4'd1, 12'h5a5, 1, 4'd0);
        drive(1, 1, 4'd9, 1, 1, 4'd9, 12'h777, 1, 4'd1);
        drive(0, 1, 4'd1, 1, 1, 4'd2, 12'heee, 1, 4'd1);
        for (int i = 0; i < 16; i++) drive(1, 0, 4'd0, 0, 0, 4'd0, 12'h000, 0, 4'(i));
        for (int i = 0; i < 16; i++) drive(1, 1, 4'(i), 1, 0, 4'd0, 12'h000, 0, 4'd0);
        drive(1, 0, 4'd0, 0, 0, 4'd0, 12'h000, 0, 4'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Programmable colour palette for the VGA display path; successor to the fixed 8-entry colour converter.
- Maps a colour index to an RGB word through a register-file palette. The palette resets to the standard game colours, and the CPU can rewrite it at run time.
- Adds a registered lookup pipeline with a valid tag, per-entry blink attributes driven by an internal blink timer, and a CPU readback port.
- Sits between the display character/tile logic and the VGA RGB output register.

Parameters:
- ID_W, 4, colour index width; DEPTH = 2**ID_W entries (derived localparam).
- COLOR_W, 12, RGB word width; must be a multiple of 3 and >= 12; channel order R,G,B from MSB.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.
- BLANK_COLOR, 12'h000, colour substituted for a blinking entry during its off phase (COLOR_W wide).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  lookup request strobe (pixel stream)
- color_id  in  ID_W  index to look up
- out_valid  out  1  in_valid delayed by one cycle
- color  out  COLOR_W  looked-up RGB
- blink_en  in  1  global blink enable
- wr_en  in  1  CPU palette write strobe
- wr_addr  in  ID_W  entry to write
- wr_data  in  COLOR_W  new colour
- wr_blink  in  1  new blink attribute for the entry
- rd_addr  in  ID_W  CPU readback index
- rd_data  out  COLOR_W+1  {blink bit, colour} of rd_addr, registered

Behaviour:
- Reset (rst_n=0 at a clk edge) loads the default palette and clears all blink bits. out_valid=0, color=0, rd_data=0, blink counter=0, phase=0.
- Default palette at 4 bits/channel: 0:444, 1:ccc, 2:0f0, 3:0c0, 4:ff0, 5:dd0, 6:f00, 7:d00, all others 111.
  - For COLOR_W>12, each 4-bit channel nibble is placed in the channel MSBs and the low bits are zero.
  - For ID_W<3, only the first DEPTH defaults are used.
- Lookup latency is 1 cycle: color_id sampled at edge t produces color at t+1, with out_valid(t+1)=in_valid(t).
- When in_valid=0, color holds its previous value.
- Write: on wr_en, entry[wr_addr] and blink[wr_addr] update at the edge.
- Write/read collision: if wr_en and in_valid target the same index in the same cycle, color returns wr_data (write-forwarded), with blink resolved from wr_blink. The same forwarding applies to rd_addr==wr_addr.
- Blink timer:
  - The counter runs 0..BLINK_DIV-1 continuously; at terminal count it wraps to 0 and phase toggles.
  - While blink_en=0, the counter and phase hold at 0. Deasserting blink_en resets both to 0 at the next edge.
- Output select: if blink_en && phase && blink-of-entry, then color=BLANK_COLOR; otherwise color=entry colour. Phase is sampled in the same cycle as color_id.
- rd_data latency is 1 cycle, always updating regardless of in_valid.
- Reset mid-stream: the pipeline drops its in-flight valid (out_valid=0 on the next cycle), and all CPU writes are lost.
- Simultaneous wr_en and reset: reset wins.

Decomposition:
- Shared package (display_pkg): default palette constant array (4-bit/channel form), COLOR_W default, and the nibble-expansion function.
- One natural sub-module, blink_timer (counter + phase, params BLINK_DIV), reusable for cursor blink elsewhere in the display path.
- Palette storage and the lookup pipeline stay in palette_lut.

Test Plan:
- Reset defaults: release rst_n, sweep in_valid with ids 0..15 -> color sequence 444,ccc,0f0,0c0,ff0,dd0,f00,d00, then 111 x8, each 1 cycle after request; out_valid tracks in_valid.
- Write then read: wr_en addr 3 data abc blink 0, then id 3 -> color abc. Readback rd_addr 3 -> rd_data {0,abc}.
- Collision forwarding: wr_en addr 5 data 123 and in_valid id 5 in the same cycle -> next cycle color=123 (not dd0).
- Blink (BLINK_DIV=4): write entry 6 with blink=1, blink_en=1, constant id 6 -> color alternates f00 x4 cycles then 000 x4 cycles. A non-blink id 2 stays 0f0 throughout.
- blink_en drop: deassert mid off-phase -> the next lookup returns the entry colour, and the counter restarts at 0 on re-enable.
- Reset mid-operation: after custom writes, assert rst_n=0 for 1 cycle with in_valid=1 -> out_valid=0 and color=0 after the edge; palette reads back defaults and blink bits are 0.
